seg_decoder_monitor: RTL and testbench

SEG_DECODER_MONITOR -- requirements
Module: seg_decoder_monitor

---
 rtl/seg_decoder_monitor.sv | 162 ++++++++++++++++
 tb/tb_seg_decoder_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_decoder_monitor.sv
// Decodes four synchronized active-low 7-segment digits into two binary values once the
// pattern has been stable. Optional sequence checker enabled by SEG_DECODER_MONITOR_SEQCHK_EN.
module seg_decoder_monitor #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       CLK_50MHz,
  input  logic       rst_n,
  input  logic [6:0] HexMSBH,
  input  logic [6:0] HexMSBL,
  input  logic [6:0] HexLSBH,
  input  logic [6:0] HexLSBL,
  input  logic       ModeSel,
  output logic [7:0] msb_val,
  output logic [7:0] lsb_val,
  output logic       val_valid,
  output logic       pat_err,
  output logic       seq_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  // Returns {illegal, digit}; anything outside the ten known glyphs is illegal.
  function automatic logic [4:0] seg_dec(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h40:   r = 5'd0;
      7'h79:   r = 5'd1;
      7'h24:   r = 5'd2;
      7'h30:   r = 5'd3;
      7'h19:   r = 5'd4;
      7'h12:   r = 5'd5;
      7'h02:   r = 5'd6;
      7'h78:   r = 5'd7;
      7'h00:   r = 5'd8;
      7'h10:   r = 5'd9;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [28:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [27:0] word_q, word_d, last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  msb_q, msb_d, lsb_q, lsb_d, err_q, err_d;
  logic        vv_q, vv_d, pe_q, pe_d, se_q, se_d;
  logic [4:0]  dec_mh, dec_ml, dec_lh, dec_ll;
  logic [7:0]  msb_n, lsb_n;
  logic        accept, legal;

  always_comb begin
    sync1_d = {ModeSel, HexMSBH, HexMSBL, HexLSBH, HexLSBL};
    sync2_d = sync1_q;
    word_d  = sync2_q[27:0];
    if (sync2_q[27:0] != word_q) cnt_d = '0;
    else if (cnt_q != STABLE)    cnt_d = cnt_q + 8'd1;
    else                         cnt_d = cnt_q;
    // Accept only on the clock the count first reaches the threshold, so held words fire once.
    accept = (cnt_d == STABLE) && (cnt_q != STABLE) && (word_q != last_q);
    dec_mh = seg_dec(word_q[27:21]);
    dec_ml = seg_dec(word_q[20:14]);
    dec_lh = seg_dec(word_q[13:7]);
    dec_ll = seg_dec(word_q[6:0]);
    legal  = !(dec_mh[4] | dec_ml[4] | dec_lh[4] | dec_ll[4]);
    msb_n  = 8'(dec_mh[3:0]) * 8'd10 + 8'(dec_ml[3:0]);
    lsb_n  = 8'(dec_lh[3:0]) * 8'd10 + 8'(dec_ll[3:0]);
    last_d = accept ? word_q : last_q;
    vv_d   = accept && legal;
    pe_d   = accept && !legal;
    msb_d  = vv_d ? msb_n : msb_q;
    lsb_d  = vv_d ? lsb_n : lsb_q;
  end

`ifdef SEG_DECODER_MONITOR_SEQCHK_EN
  logic        primed_q, primed_d, mode_q, mode_d;
  logic [7:0]  pmsb_q, pmsb_d, plsb_q, plsb_d;
  logic [13:0] tot_prev, tot_new;
  logic        mode_chg, seq_ok;

  always_comb begin
    mode_d   = sync2_q[28];
    mode_chg = (sync2_q[28] != mode_q);
    tot_prev = 14'(pmsb_q) * 14'd100 + 14'(plsb_q);
    tot_new  = 14'(msb_n) * 14'd100 + 14'(lsb_n);
    if (!sync2_q[28])         seq_ok = (tot_new == tot_prev + 14'd1);
    else if (plsb_q < 8'd59)  seq_ok = (msb_n == pmsb_q) && (lsb_n == plsb_q + 8'd1);
    else                      seq_ok = (msb_n == pmsb_q + 8'd1) && (lsb_n == 8'd0);
    // 00:00 is a counter reset and always legal; covers both wrap cases too.
    if (msb_n == 8'd0 && lsb_n == 8'd0) seq_ok = 1'b1;
    se_d     = vv_d && primed_q && !mode_chg && !seq_ok;
    primed_d = mode_chg ? 1'b0 : primed_q;
    pmsb_d   = pmsb_q;
    plsb_d   = plsb_q;
    if (vv_d) begin
      primed_d = 1'b1;
      pmsb_d   = msb_n;
      plsb_d   = lsb_n;
    end
  end

  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      mode_q   <= 1'b0;
      pmsb_q   <= '0;
      plsb_q   <= '0;
    end else begin
      primed_q <= primed_d;
      mode_q   <= mode_d;
      pmsb_q   <= pmsb_d;
      plsb_q   <= plsb_d;
    end
  end
`else
  logic mode_unused;
  always_comb begin
    se_d        = 1'b0;
    mode_unused = sync2_q[28];
  end
`endif

  always_comb begin
    err_d = err_q;
    if ((pe_d || se_d) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      word_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
      err_q   <= '0;
      vv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      word_q  <= word_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      err_q   <= err_d;
      vv_q    <= vv_d;
      pe_q    <= pe_d;
      se_q    <= se_d;
    end
  end

  assign msb_val   = msb_q;
  assign lsb_val   = lsb_q;
  assign val_valid = vv_q;
  assign pat_err   = pe_q;
  assign seq_err   = se_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_seg_decoder_monitor.sv
// Bench for seg_decoder_monitor: directed scenarios plus random segment streams checked every
// cycle against a word/segment-level reference model.
module tb_seg_decoder_monitor;
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] HexMSBH, HexMSBL, HexLSBH, HexLSBL;
  logic       ModeSel;
  logic [7:0] msb_val, lsb_val, err_cnt;
  logic       val_valid, pat_err, seq_err;

  seg_decoder_monitor #(.STABLE_CYCLES(S)) dut (
    .CLK_50MHz(clk), .rst_n(rst_n),
    .HexMSBH(HexMSBH), .HexMSBL(HexMSBL), .HexLSBH(HexLSBH), .HexLSBL(HexLSBL),
    .ModeSel(ModeSel), .msb_val(msb_val), .lsb_val(lsb_val),
    .val_valid(val_valid), .pat_err(pat_err), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int dig(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [27:0] mkval(input int m, input int l);
    return {seg_tab[m / 10], seg_tab[m % 10], seg_tab[l / 10], seg_tab[l % 10]};
  endfunction

  // Reference model state
  logic [27:0] last_acc;
  int          m_msb, m_lsb, m_err;
  bit          e_vv, e_pe, e_se;
  bit          cur_v, pnd_v, cur_m, pnd_m, mode_drv;
  int          cur_e, pnd_at;
  logic [27:0] cur_w, pnd_w;
`ifdef SEG_DECODER_MONITOR_SEQCHK_EN
  bit primed;
  int pm, pl;
`endif

  task automatic model_reset();
    last_acc = '0; m_msb = 0; m_lsb = 0; m_err = 0;
    e_vv = 0; e_pe = 0; e_se = 0; cur_v = 0; pnd_v = 0;
`ifdef SEG_DECODER_MONITOR_SEQCHK_EN
    primed = 0; pm = 0; pl = 0;
`endif
  endtask

  task automatic model_accept(input logic [27:0] w, input bit m);
    int d3, d2, d1, d0, nm, nl;
    bit ok;
    if (w == last_acc) return;
    last_acc = w;
    d3 = dig(w[27:21]); d2 = dig(w[20:14]); d1 = dig(w[13:7]); d0 = dig(w[6:0]);
    if (d3 < 0 || d2 < 0 || d1 < 0 || d0 < 0) begin
      e_pe = 1;
      if (m_err < 255) m_err++;
      return;
    end
    nm = d3 * 10 + d2; nl = d1 * 10 + d0;
    m_msb = nm; m_lsb = nl; e_vv = 1;
`ifdef SEG_DECODER_MONITOR_SEQCHK_EN
    if (primed && !(nm == 0 && nl == 0)) begin
      if (!m)          ok = ((nm * 100 + nl) == ((pm * 100 + pl + 1) % 10000));
      else if (pl < 59) ok = (nm == pm) && (nl == pl + 1);
      else              ok = (nm == pm + 1) && (nl == 0);
      if (!ok) begin
        e_se = 1;
        if (m_err < 255) m_err++;
      end
    end
    primed = 1; pm = nm; pl = nl;
`else
    ok = m;
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    e_vv = 0; e_pe = 0; e_se = 0;
    if (pnd_v && cyc == pnd_at) begin
      model_accept(pnd_w, pnd_m);
      pnd_v = 0;
    end
    if (cur_v && cyc == cur_e + S + 3) model_accept(cur_w, cur_m);
    check_val("val_valid", val_valid, e_vv);
    check_val("pat_err", pat_err, e_pe);
    check_val("seq_err", seq_err, e_se);
    check_val("msb_val", msb_val, m_msb);
    check_val("lsb_val", lsb_val, m_lsb);
    check_val("err_cnt", err_cnt, m_err);
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Start a new displayed word; a word held long enough but not yet accepted stays pending.
  task automatic apply(input logic [27:0] w, input bit m);
    bit mm;
    if (cur_v && w == cur_w) return;
    mm = m;
    if (cur_v && (cyc - cur_e) >= S + 1 && cyc < cur_e + S + 3) begin
      pnd_v = 1; pnd_at = cur_e + S + 3; pnd_w = cur_w; pnd_m = cur_m;
      mm = mode_drv;
    end
`ifdef SEG_DECODER_MONITOR_SEQCHK_EN
    if (mm != mode_drv) primed = 0;
`endif
    {HexMSBH, HexMSBL, HexLSBH, HexLSBL} = w;
    ModeSel = mm; mode_drv = mm;
    cur_v = 1; cur_e = cyc; cur_w = w; cur_m = mm;
  endtask

  task automatic do_reset(input logic [27:0] w, input bit m);
    rst_n = 1'b0;
    model_reset();
    hold(3);
    check_val("rst_msb", msb_val, 0);
    check_val("rst_lsb", lsb_val, 0);
    check_val("rst_err", err_cnt, 0);
    check_val("rst_vv", val_valid, 0);
    rst_n = 1'b1;
    apply(w, m);
  endtask

  int          sel, hl, gm, gl;
  logic [27:0] w;

  initial begin
    rst_n = 1'b0; ModeSel = 1'b0; mode_drv = 1'b0;
    {HexMSBH, HexMSBL, HexLSBH, HexLSBL} = '0;
    model_reset();
    hold(2);
    // Reset, then 00:00 held 20 clocks: valid at clock 19
    rst_n = 1'b1;
    apply(mkval(0, 0), 0);
    hold(20);
    // Mode 0 increment without error
    do_reset(mkval(12, 34), 0);
    hold(30);
    apply(mkval(12, 35), 0); hold(30);
    check_val("lsb_35", lsb_val, 35);
    // Skipped value, then recovery
    apply(mkval(12, 37), 0); hold(30);
    apply(mkval(12, 38), 0); hold(30);
    // Mode 1 wrap and minute rollover
    apply(mkval(1, 59), 1); hold(30);
    apply(mkval(0, 0), 1);  hold(30);
    apply(mkval(0, 1), 1);  hold(30);
    apply(mkval(0, 59), 1); hold(30);
    apply(mkval(0, 61), 1); hold(30);
    // Blank lower units digit
    w = mkval(0, 61); w[6:0] = 7'h7F;
    apply(w, 1); hold(30);
    check_val("hold_msb", msb_val, 0);
    check_val("hold_lsb", lsb_val, 61);
    // Force 256 pattern errors to saturate the counter
    for (int i = 0; i < 256; i++) begin
      w = mkval(0, 61); w[6:0] = (i % 2 == 0) ? 7'h7E : 7'h7F;
      apply(w, 1); hold(S + 4);
    end
    check_val("err_sat", err_cnt, 255);
    // Pattern toggling every 5 clocks never settles
    for (int i = 0; i < 40; i++) begin
      apply((i % 2 == 0) ? mkval(22, 22) : mkval(33, 33), 0); hold(5);
    end
    // Reset in the middle of a stability count
    apply(mkval(44, 44), 0); hold(8);
    do_reset(mkval(0, 1), 0);
    hold(25);
    // Randomized segment stream
    gm = 0; gl = 1;
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 19) == 0) begin
        mode_drv = ~mode_drv; gm = 0; gl = 0;
      end
      if (sel < 7) begin
        if (!mode_drv) begin
          gl = gl + 1;
          if (gl == 100) begin gl = 0; gm = (gm + 1) % 100; end
        end else if (gl < 59) gl = gl + 1;
        else begin gl = 0; gm = (gm + 1) % 2; end
      end else begin
        gm = $urandom_range(0, mode_drv ? 1 : 99);
        gl = $urandom_range(0, mode_drv ? 59 : 99);
      end
      w = mkval(gm, gl);
      if (sel == 9) w[$urandom_range(0, 27)] ^= 1'b1;
      if (w == cur_w) w ^= 28'h7F;
      hl = ($urandom_range(0, 3) == 0) ? $urandom_range(2, S + 3) : $urandom_range(S + 1, S + 12);
      apply(w, mode_drv ^ ($urandom_range(0, 9) == 0));
      hold(hl);
    end
    hold(S + 5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
